// File: rtl/img_stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_stream_packer_pkg
// Description : Shared image geometry, derived sizes and buffer-select type
//               for the pixel-stream packer feeding top_cnn.
// Revision    : 1.0 - initial release
// ============================================================================
package img_stream_packer_pkg;

  // Default image geometry shared with top_cnn
  localparam int IMG_W_DEF    = 12;
  localparam int IMG_H_DEF    = 12;
  localparam int PIX_W_DEF    = 8;
  localparam int CNT_W_DEF    = 8;
  localparam int NPIX_DEF     = IMG_W_DEF * IMG_H_DEF;
  localparam int IMG_BITS_DEF = NPIX_DEF * PIX_W_DEF;

  // Identifies one half of the ping-pong buffer pair
  typedef enum logic {
    BUF_0 = 1'b0,
    BUF_1 = 1'b1
  } buf_sel_e;

  // Returns the opposite half of the ping-pong pair
  function automatic buf_sel_e other_buf(input buf_sel_e sel);
    return (sel == BUF_0) ? BUF_1 : BUF_0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : img_frame_buf
// Description : One full-frame buffer. Pixels are written one slice at a
//               time by index; a full flag marks a committed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module img_frame_buf #(
  parameter int PIX_W = 8,
  parameter int NPIX  = 144,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_idx,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  set_full,
  input  logic                  clr_full,
  output logic [NPIX*PIX_W-1:0] data,
  output logic                  full
);

  logic [NPIX*PIX_W-1:0] r_data;
  logic                  r_full;
  logic [NPIX-1:0]       w_slice_we;

  // One write enable per pixel slot, decoded from the fill index
  for (genvar k = 0; k < NPIX; k++) begin : g_dec
    assign w_slice_we[k] = wr_en && (wr_idx == CNT_W'(k));
  end

  // Pixel storage: only the addressed slice changes on a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      for (int k = 0; k < NPIX; k++) begin
        if (w_slice_we[k]) begin
          r_data[k*PIX_W +: PIX_W] <= wr_data;
        end
      end
    end
  end

  // Full flag: commit sets it, consume clears it (never both on one buffer)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (set_full) begin
      r_full <= 1'b1;
    end else if (clr_full) begin
      r_full <= 1'b0;
    end
  end

  assign data = r_data;
  assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/img_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : img_stream_packer
// Description : Packs a serial pixel stream into flat image vectors for
//               top_cnn using a ping-pong pair of frame buffers, and flags
//               frames whose length disagrees with the end-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
module img_stream_packer
  import img_stream_packer_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               pix_data,
  input  logic                           pix_valid,
  input  logic                           pix_last,
  output logic                           pix_ready,
  output logic [IMG_W*IMG_H*PIX_W-1:0]   img_source,
  output logic                           img_valid,
  input  logic                           img_ready,
  output logic                           frame_err
);

  localparam int NPIX     = IMG_W * IMG_H;
  localparam int IMG_BITS = NPIX * PIX_W;

  buf_sel_e            r_wr_sel;
  buf_sel_e            r_rd_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_frame_err;

  logic [1:0]          w_full;
  logic [IMG_BITS-1:0] w_buf_data [2];
  logic [1:0]          w_buf_we;
  logic [1:0]          w_buf_set;
  logic [1:0]          w_buf_clr;
  logic                w_accept;
  logic                w_last_slot;
  logic                w_commit;
  logic                w_consume;

  // Handshake terms derived from registered state only
  assign pix_ready   = ~w_full[r_wr_sel];
  assign w_accept    = pix_valid & pix_ready;
  assign w_last_slot = (r_cnt == CNT_W'(NPIX - 1));
  // A frame commits on its 144th pixel regardless of the marker
  assign w_commit    = w_accept & w_last_slot;
  assign img_valid   = w_full[r_rd_sel];
  assign w_consume   = img_valid & img_ready;
  assign img_source  = (r_rd_sel == BUF_1) ? w_buf_data[1] : w_buf_data[0];
  assign frame_err   = r_frame_err;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    assign w_buf_we[b]  = w_accept  & (r_wr_sel == buf_sel_e'(b));
    assign w_buf_set[b] = w_commit  & (r_wr_sel == buf_sel_e'(b));
    assign w_buf_clr[b] = w_consume & (r_rd_sel == buf_sel_e'(b));

    img_frame_buf #(
      .PIX_W (PIX_W),
      .NPIX  (NPIX),
      .CNT_W (CNT_W)
    ) u_frame_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (w_buf_we[b]),
      .wr_idx   (r_cnt),
      .wr_data  (pix_data),
      .set_full (w_buf_set[b]),
      .clr_full (w_buf_clr[b]),
      .data     (w_buf_data[b]),
      .full     (w_full[b])
    );
  end

  // Fill counter restarts after a committed frame or an early end marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last_slot || pix_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Write and read pointers advance independently on commit and consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_sel <= BUF_0;
      r_rd_sel <= BUF_0;
    end else begin
      if (w_commit) begin
        r_wr_sel <= other_buf(r_wr_sel);
      end
      if (w_consume) begin
        r_rd_sel <= other_buf(r_rd_sel);
      end
    end
  end

  // Framing error: marker present on a non-final pixel or absent on the final one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept & (w_last_slot ^ pix_last);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_img_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_stream_packer
// Description : Self-checking bench for img_stream_packer. A frame-level
//               reference model (queue of pending images) predicts the
//               handshake, image contents and framing-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_stream_packer;
  import img_stream_packer_pkg::*;

  localparam int NP = 144;
  localparam int IB = NP * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [IB-1:0] img_source;
  logic          img_valid;
  logic          img_ready;
  logic          frame_err;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: completed frames waiting for top_cnn, frame in progress
  logic [IB-1:0] exp_q [$];
  logic [IB-1:0] cur_img;
  int            cur_n;
  logic          exp_err;

  img_stream_packer dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .img_source (img_source),
    .img_valid  (img_valid),
    .img_ready  (img_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_source(input logic [IB-1:0] e);
    for (int i = 0; i < IB / 64; i++) begin
      check_val($sformatf("img_source[%0d]", i), img_source[64*i +: 64], e[64*i +: 64]);
    end
  endtask

  task automatic check_outputs();
    logic [IB-1:0] e;
    check_val("pix_ready", {63'd0, pix_ready}, {63'd0, (exp_q.size() < 2)});
    check_val("img_valid", {63'd0, img_valid}, {63'd0, (exp_q.size() > 0)});
    check_val("frame_err", {63'd0, frame_err}, {63'd0, exp_err});
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check_source(e);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_n   = 0;
    exp_err = 1'b0;
    cur_img = '0;
  endtask

  // One clock: check outputs, apply inputs, advance the model at the edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic r, output logic acc);
    logic cons;
    logic nerr;
    check_outputs();
    pix_valid = v;
    pix_data  = d;
    pix_last  = l;
    img_ready = r;
    acc  = v && (exp_q.size() < 2);
    cons = (exp_q.size() > 0) && r;
    @(posedge clk);
    nerr = 1'b0;
    if (cons) void'(exp_q.pop_front());
    if (acc) begin
      cur_img[8*cur_n +: 8] = d;
      cur_n++;
      if (cur_n == NP) begin
        exp_q.push_back(cur_img);
        nerr  = !l;
        cur_n = 0;
      end else if (l) begin
        nerr  = 1'b1;
        cur_n = 0;
      end
    end
    exp_err = nerr;
    @(negedge clk);
  endtask

  // mode 0: img_ready low except a single pulse after 5 stalled cycles
  // mode 1: img_ready high, mode 2: img_ready random
  task automatic send_pixel(input logic [7:0] d, input logic l, input int mode);
    logic acc;
    logic r;
    int   stall;
    acc   = 1'b0;
    stall = 0;
    while (!acc) begin
      case (mode)
        0:       r = (stall == 5);
        1:       r = 1'b1;
        default: r = ($urandom_range(0, 3) == 0);
      endcase
      cycle(1'b1, d, l, r, acc);
      if (!acc) begin
        stall++;
        if (stall > 200) begin
          check_val("accept_timeout", 64'd0, 64'd1);
          return;
        end
      end
    end
  endtask

  task automatic send_frame(input int n_pix, input int last_at, input int mode, input int base);
    for (int k = 0; k < n_pix; k++) begin
      send_pixel(8'(k + base), (k == last_at), mode);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 8'($urandom), 1'b0, r, acc);
    end
  endtask

  initial begin
    logic acc;
    logic v;
    logic l;
    logic r;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    img_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    check_source('0);
    rst = 1'b0;

    // Single frame k=0..143, held until img_ready
    send_frame(NP, NP - 1, 0, 0);
    idle(6, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Back-pressure: three frames, third stalls until a consume pulse
    send_frame(NP, NP - 1, 0, 16);
    send_frame(NP, NP - 1, 0, 64);
    send_frame(NP, NP - 1, 0, 128);
    idle(8, 1'b1);

    // Short frame then a full one
    send_frame(100, 99, 1, 3);
    idle(3, 1'b0);
    send_frame(NP, NP - 1, 1, 200);
    idle(4, 1'b1);

    // Missing end marker: committed with error
    send_frame(NP, -1, 0, 77);
    idle(4, 1'b0);
    idle(3, 1'b1);

    // Reset mid-frame, asserted away from the clock edge
    send_frame(50, -1, 1, 9);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);
    send_frame(NP, NP - 1, 0, 33);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with phases of heavy and light back-pressure
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (cur_n == NP - 1) l = ($urandom_range(0, 7) != 0);
      else                 l = ($urandom_range(0, 199) == 0);
      if (((i / 400) % 2) == 1) r = ($urandom_range(0, 15) == 0);
      else                      r = ($urandom_range(0, 2) != 0);
      cycle(v, 8'($urandom), l, r, acc);
    end
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
